// File: rtl/stack_based_alu.sv
// Stack-based ALU: push/pop operands on an internal LIFO and add or multiply the
// two topmost entries, with registered result, overflow and success flags.
module stack_based_alu #(
  parameter int N        = 4,
  parameter int MAX_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] input_data,
  output logic [N-1:0] output_data,
  output logic         overflow,
  output logic         success
);

  localparam int CW = $clog2(MAX_SIZE + 1);
  localparam int AW = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;

  logic [N-1:0]   mem [MAX_SIZE];

  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           succ_q, succ_d;

  logic           wr_en;
  logic [AW-1:0]  wr_idx, top_idx, nxt_idx;
  logic [N-1:0]   top_val, nxt_val;
  logic [N-1:0]   sum;
  logic           add_ovf;
  logic [2*N-1:0] a_x, b_x, prod;
  logic [N:0]     prod_hi;
  logic           mul_ovf;

  assign wr_idx  = AW'(count_q);
  assign top_idx = AW'(count_q - CW'(1));
  assign nxt_idx = AW'(count_q - CW'(2));
  assign top_val = mem[top_idx];
  assign nxt_val = mem[nxt_idx];

  // Signed overflow: operands agree in sign but the truncated sum does not.
  assign sum     = top_val + nxt_val;
  assign add_ovf = (top_val[N-1] == nxt_val[N-1]) && (sum[N-1] != top_val[N-1]);

  // Sign-extended operands make the low 2N bits of the product the exact signed result.
  assign a_x     = {{N{top_val[N-1]}}, top_val};
  assign b_x     = {{N{nxt_val[N-1]}}, nxt_val};
  assign prod    = a_x * b_x;
  assign prod_hi = prod[2*N-1:N-1];
  assign mul_ovf = ~((&prod_hi) | ~(|prod_hi));

  always_comb begin
    count_d = count_q;
    out_d   = out_q;
    ovf_d   = 1'b0;
    succ_d  = 1'b0;
    wr_en   = 1'b0;
    case (opcode)
      OP_PUSH: begin
        if (count_q < CW'(MAX_SIZE)) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          succ_d  = 1'b1;
        end
      end
      OP_POP: begin
        if (count_q != '0) begin
          out_d   = top_val;
          count_d = count_q - CW'(1);
          succ_d  = 1'b1;
        end
      end
      OP_ADD: begin
        if (count_q >= CW'(2)) begin
          out_d  = sum;
          ovf_d  = add_ovf;
          succ_d = 1'b1;
        end
      end
      OP_MUL: begin
        if (count_q >= CW'(2)) begin
          out_d  = prod[N-1:0];
          ovf_d  = mul_ovf;
          succ_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      succ_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      succ_q  <= succ_d;
    end
  end

  // Storage is not reset; entries above count are unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= input_data;
  end

  assign output_data = out_q;
  assign overflow    = ovf_q;
  assign success     = succ_q;

endmodule

// File: tb/tb_stack_based_alu.sv
// Self-checking bench for stack_based_alu: directed vector tables, a small-depth
// stack instance, randomized traffic against a queue-based model, and async reset.
module tb_stack_based_alu;

  localparam int N    = 4;
  localparam int MS   = 8;
  localparam int MS_S = 2;

  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;
  localparam logic [2:0] NOP  = 3'b010;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   op_m, op_s;
  logic [N-1:0] din_m, din_s;
  logic [N-1:0] out_m, out_s;
  logic         ovf_m, ovf_s, succ_m, succ_s;

  always #5 clk = ~clk;

  stack_based_alu #(.N(N), .MAX_SIZE(MS)) dut (
    .clk(clk), .rst(rst), .opcode(op_m), .input_data(din_m),
    .output_data(out_m), .overflow(ovf_m), .success(succ_m)
  );

  stack_based_alu #(.N(N), .MAX_SIZE(MS_S)) dut_s (
    .clk(clk), .rst(rst), .opcode(op_s), .input_data(din_s),
    .output_data(out_s), .overflow(ovf_s), .success(succ_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integer stack.
  int q[$];
  int m_out;
  bit m_ovf, m_succ;

  typedef struct {
    logic [2:0] op;
    int         din;
    int         eout;
    bit         eovf;
    bit         esucc;
  } vec_t;

  vec_t vt_s[$];
  vec_t vt_m[$];

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrap(input int r);
    int t;
    t = r & ((1 << N) - 1);
    if (t >= (1 << (N - 1))) t = t - (1 << N);
    return t;
  endfunction

  task automatic model_step(input logic [2:0] op, input int din);
    int r;
    m_ovf  = 1'b0;
    m_succ = 1'b0;
    case (op)
      PUSH: if (q.size() < MS) begin q.push_back(wrap(din)); m_succ = 1'b1; end
      POP:  if (q.size() > 0) begin m_out = q.pop_back(); m_succ = 1'b1; end
      ADD, MUL: if (q.size() >= 2) begin
        r = (op == ADD) ? q[q.size()-1] + q[q.size()-2] : q[q.size()-1] * q[q.size()-2];
        m_ovf  = (r > (1 << (N - 1)) - 1) || (r < -(1 << (N - 1)));
        m_out  = wrap(r);
        m_succ = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic apply_m(input logic [2:0] op, input int din);
    @(negedge clk);
    op_m  = op;
    din_m = N'(din);
    op_s  = NOP;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_s(input logic [2:0] op, input int din);
    @(negedge clk);
    op_s  = op;
    din_s = N'(din);
    op_m  = NOP;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string nm);
    check({nm, ".out"}, $signed(out_m), m_out);
    check({nm, ".ovf"}, ovf_m, m_ovf);
    check({nm, ".succ"}, succ_m, m_succ);
  endtask

  initial begin
    int r, d;
    logic [2:0] op;

    // Small-stack sequence: fills to depth 2, rejects the third push, drains, underflows.
    vt_s.push_back('{PUSH, 1, 0, 1'b0, 1'b1});
    vt_s.push_back('{PUSH, 2, 0, 1'b0, 1'b1});
    vt_s.push_back('{PUSH, 7, 0, 1'b0, 1'b0});
    vt_s.push_back('{POP,  0, 2, 1'b0, 1'b1});
    vt_s.push_back('{POP,  0, 1, 1'b0, 1'b1});
    vt_s.push_back('{POP,  0, 1, 1'b0, 1'b0});

    vt_m.push_back('{POP,  0,  0, 1'b0, 1'b0});
    vt_m.push_back('{PUSH, 3,  0, 1'b0, 1'b1});
    vt_m.push_back('{PUSH, 5,  0, 1'b0, 1'b1});
    vt_m.push_back('{ADD,  0, -8, 1'b1, 1'b1});
    vt_m.push_back('{POP,  0,  5, 1'b0, 1'b1});
    vt_m.push_back('{POP,  0,  3, 1'b0, 1'b1});
    vt_m.push_back('{PUSH, -2, 3, 1'b0, 1'b1});
    vt_m.push_back('{PUSH, 3,  3, 1'b0, 1'b1});
    vt_m.push_back('{MUL,  0, -6, 1'b0, 1'b1});
    vt_m.push_back('{PUSH, 4, -6, 1'b0, 1'b1});
    vt_m.push_back('{MUL,  0, -4, 1'b1, 1'b1});
    vt_m.push_back('{POP,  0,  4, 1'b0, 1'b1});
    vt_m.push_back('{POP,  0,  3, 1'b0, 1'b1});
    vt_m.push_back('{POP,  0, -2, 1'b0, 1'b1});
    vt_m.push_back('{PUSH, 1, -2, 1'b0, 1'b1});
    vt_m.push_back('{ADD,  0, -2, 1'b0, 1'b0});
    vt_m.push_back('{POP,  0,  1, 1'b0, 1'b1});
    vt_m.push_back('{NOP,  0,  1, 1'b0, 1'b0});
    vt_m.push_back('{MUL,  0,  1, 1'b0, 1'b0});

    rst   = 1'b0;
    op_m  = NOP;
    op_s  = NOP;
    din_m = '0;
    din_s = '0;
    m_out = 0;
    #12;
    check("rst.out", $signed(out_m), 0);
    check("rst.ovf", ovf_m, 0);
    check("rst.succ", succ_m, 0);
    check("rst.succ_s", succ_s, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt_s[i]) begin
      apply_s(vt_s[i].op, vt_s[i].din);
      check($sformatf("small[%0d].out", i), $signed(out_s), vt_s[i].eout);
      check($sformatf("small[%0d].ovf", i), ovf_s, vt_s[i].eovf);
      check($sformatf("small[%0d].succ", i), succ_s, vt_s[i].esucc);
    end

    foreach (vt_m[i]) begin
      apply_m(vt_m[i].op, vt_m[i].din);
      model_step(vt_m[i].op, vt_m[i].din);
      check($sformatf("vec[%0d].out", i), $signed(out_m), vt_m[i].eout);
      check($sformatf("vec[%0d].ovf", i), ovf_m, vt_m[i].eovf);
      check($sformatf("vec[%0d].succ", i), succ_m, vt_m[i].esucc);
    end

    // Held opcode executes once per edge.
    @(negedge clk);
    op_m  = PUSH;
    din_m = 4'd6;
    op_s  = NOP;
    repeat (3) begin
      @(posedge clk);
      #1;
      model_step(PUSH, 6);
      check_model("hold_push");
    end
    @(negedge clk);
    op_m = POP;
    repeat (4) begin
      @(posedge clk);
      #1;
      model_step(POP, 0);
      check_model("hold_pop");
    end

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      d = wrap(int'($urandom_range(0, 15)));
      if (r <= 3)      op = PUSH;
      else if (r <= 5) op = POP;
      else if (r == 6) op = ADD;
      else if (r == 7) op = MUL;
      else             op = 3'($urandom_range(0, 3));
      apply_m(op, d);
      model_step(op, d);
      check_model($sformatf("rand[%0d]", i));
    end

    // Mid-cycle asynchronous reset discards the stack.
    while (q.size() > 0) begin
      apply_m(POP, 0);
      model_step(POP, 0);
      check_model("drain");
    end
    for (int k = 1; k <= 4; k++) begin
      apply_m(PUSH, k);
      model_step(PUSH, k);
    end
    apply_m(POP, 0);
    model_step(POP, 0);
    check_model("pre_rst_pop");
    @(negedge clk);
    op_m = NOP;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.out", $signed(out_m), 0);
    check("async_rst.ovf", ovf_m, 0);
    check("async_rst.succ", succ_m, 0);
    q.delete();
    m_out  = 0;
    m_ovf  = 1'b0;
    m_succ = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    apply_m(POP, 0);
    model_step(POP, 0);
    check_model("post_rst_pop");
    check("post_rst_pop.succ0", succ_m, 0);
    apply_m(ADD, 0);
    model_step(ADD, 0);
    check_model("post_rst_add");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_based_alu.md
STACK_BASED_ALU -- requirements
Module: stack_based_alu

Interface
REQ-001 Parameter N, default 4, data width in bits (signed two's complement).
REQ-002 Parameter MAX_SIZE, default 1024, stack depth in entries.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 opcode  input  3  operation select, sampled every rising edge.
REQ-006 input_data  input  N  signed operand for push.
REQ-007 output_data  output  N  signed registered result (pop value or arithmetic result).
REQ-008 overflow  output  1  registered; set when the last arithmetic result did not fit in N bits.
REQ-009 success  output  1  registered; set when the last sampled operation completed legally.

Function
REQ-010 Opcode map SHALL be: 100 add, 101 multiply, 110 push, 111 pop, 000-011 no-op.
REQ-011 Each opcode value held across a rising edge SHALL execute exactly once per edge; holding an opcode for k cycles executes it k times.
REQ-012 The stack SHALL hold up to MAX_SIZE N-bit entries with a pointer `count` (0..MAX_SIZE); the top is the most recently pushed entry.
REQ-013 Push: if count<MAX_SIZE, store input_data at top, count+1, success=1, overflow=0, output_data unchanged.
REQ-014 Push when count==MAX_SIZE: stack unchanged, success=0, overflow=0, output_data unchanged.
REQ-015 Pop: if count>0, output_data=top entry, count-1, success=1, overflow=0.
REQ-016 Pop when count==0: stack unchanged, success=0, overflow=0, output_data unchanged.
REQ-017 Add/multiply SHALL read the top two entries (top and top-1) without removing or modifying them; count unchanged.
REQ-018 Add: output_data = low N bits of signed sum; overflow=1 iff both operands have the same sign and the N-bit result sign differs.
REQ-019 Multiply: full 2N-bit signed product computed; output_data = low N bits; overflow=1 iff product bits [2N-1:N-1] are not all equal.
REQ-020 Add/multiply with count>=2: success=1.
REQ-021 Add/multiply with count<2: output_data unchanged, overflow=0, success=0.
REQ-022 No-op: stack and output_data unchanged, overflow=0, success=0.
REQ-023 Result latency SHALL be one clock: outputs reflect the operation sampled at the most recent rising edge.
REQ-024 Outputs SHALL be purely registered (no combinational path from opcode/input_data).

Reset
REQ-025 While rst=0, count=0, output_data=0, overflow=0, success=0, asynchronously, independent of clk.
REQ-026 Stack storage contents need not be cleared by reset; they are unreachable while count=0.
REQ-027 Reset asserted mid-sequence SHALL discard all entries; the first operation after release behaves as on an empty stack.
REQ-028 Operation resumes on the first rising edge after rst returns to 1.

Verification (N=4)
REQ-029 Reset, then pop -> success=0, output_data=0, overflow=0.
REQ-030 Push 3, push 5, add -> output_data=-8, overflow=1, success=1; then pop -> 5, pop -> 3, both success=1.
REQ-031 Push -2, push 3, multiply -> output_data=-6, overflow=0; push 4, multiply (4*3) -> output_data=-4, overflow=1.
REQ-032 Push 1 only, add -> success=0, output_data unchanged; stack still holds 1 (pop -> 1).
REQ-033 MAX_SIZE=2: push 1, push 2, push 7 -> third success=0; pop -> 2, pop -> 1, pop -> success=0.
REQ-034 Push 4 values, assert rst mid-cycle -> outputs zero immediately; after release pop -> success=0.
